// File: rtl/move_input_ctrl.sv
// -----------------------------------------------------------------------------
// move_input_ctrl
//
// Front end for game_model. Five raw push-buttons are synchronized and
// debounced. The direction buttons move a cursor over the 3x3 board, and the
// select button requests a write of the cell under the cursor. A write that
// is accepted produces a writeEn pulse WE_HOLD cycles long. The FSM then
// waits for select to be released, so game_model sees writeEn low before the
// next move.
//
// Ports
//   clk        system clock (only clock)
//   reset      synchronous, active-high
//   btn_up/btn_down/btn_left/btn_right/btn_sel
//              raw asynchronous buttons, active-high
//   X, O       cell occupancy fed back from game_model (bit i = row*3+col)
//   game_over  blocks every write while high
//   C          one-hot select of the cursor cell (always 1 << cursor)
//   writeEn    write strobe to game_model
//   cursor     current cell index 0..8
//   reject     one-cycle pulse when a select is refused
// -----------------------------------------------------------------------------
module move_input_ctrl #(
    parameter int DB_CYCLES = 4,
    parameter int DB_W      = 16,
    parameter int WE_HOLD   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_sel,
    input  logic [8:0] X,
    input  logic [8:0] O,
    input  logic       game_over,
    output logic [8:0] C,
    output logic       writeEn,
    output logic [3:0] cursor,
    output logic       reject
);

    // Bit positions of the buttons inside the packed button vectors.
    localparam int B_UP    = 0;
    localparam int B_DOWN  = 1;
    localparam int B_LEFT  = 2;
    localparam int B_RIGHT = 3;
    localparam int B_SEL   = 4;
    localparam int NBTN    = 5;

    localparam logic [3:0] CENTER = 4'd4;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        RELEASE
    } state_t;

    // -------------------------------------------------------------------------
    // Synchronizers and debouncers
    // -------------------------------------------------------------------------
    logic [NBTN-1:0] btn_raw;
    logic [NBTN-1:0] sync1;
    logic [NBTN-1:0] sync2;
    logic [NBTN-1:0] level;
    logic [NBTN-1:0] level_d;
    logic [DB_W-1:0] db_cnt [NBTN];
    logic [NBTN-1:0] press;

    assign btn_raw = {btn_sel, btn_right, btn_left, btn_down, btn_up};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= '0;
            sync2   <= '0;
            level   <= '0;
            level_d <= '0;
            // NOTE: the counter array is plain flops, not RAM, so clearing
            // it in reset is legal and keeps a button held through reset from
            // resuming a half-finished count.
            for (int i = 0; i < NBTN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments make sync2 take the *old* sync1,
            // which is what builds a two-stage synchronizer rather than a wire.
            sync1   <= btn_raw;
            sync2   <= sync1;
            level_d <= level;
            for (int i = 0; i < NBTN; i++) begin
                if (sync2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DB_CYCLES - 1)) begin
                    level[i]  <= ~level[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // One-cycle pulse on each rising edge of a debounced level.
    assign press = level & ~level_d;

    // -------------------------------------------------------------------------
    // Cursor arithmetic on the 3x3 grid (row = idx/3, col = idx%3)
    // -------------------------------------------------------------------------
    function automatic logic [1:0] col_of(input logic [3:0] idx);
        case (idx)
            4'd0, 4'd3, 4'd6: col_of = 2'd0;
            4'd1, 4'd4, 4'd7: col_of = 2'd1;
            default:          col_of = 2'd2;
        endcase
    endfunction

    function automatic logic [3:0] move_up(input logic [3:0] idx);
        move_up = (idx >= 4'd3) ? idx - 4'd3 : idx + 4'd6;
    endfunction

    function automatic logic [3:0] move_down(input logic [3:0] idx);
        move_down = (idx <= 4'd5) ? idx + 4'd3 : idx - 4'd6;
    endfunction

    function automatic logic [3:0] move_left(input logic [3:0] idx);
        move_left = (col_of(idx) == 2'd0) ? idx + 4'd2 : idx - 4'd1;
    endfunction

    function automatic logic [3:0] move_right(input logic [3:0] idx);
        move_right = (col_of(idx) == 2'd2) ? idx - 4'd2 : idx + 4'd1;
    endfunction

    // Fixed priority up > down > left > right; weaker presses in the same
    // cycle are simply lost, since press events last only one cycle.
    logic [3:0] mv_cursor;
    logic       dir_press;

    always_comb begin
        // NOTE: defaults first so every path assigns both signals and no
        // latch is inferred.
        mv_cursor = cursor;
        dir_press = 1'b1;
        if (press[B_UP]) begin
            mv_cursor = move_up(cursor);
        end else if (press[B_DOWN]) begin
            mv_cursor = move_down(cursor);
        end else if (press[B_LEFT]) begin
            mv_cursor = move_left(cursor);
        end else if (press[B_RIGHT]) begin
            mv_cursor = move_right(cursor);
        end else begin
            dir_press = 1'b0;
        end
    end

    // Occupancy is looked at only at the select press in IDLE.
    logic [8:0] occ;
    assign occ = X | O;

    // -------------------------------------------------------------------------
    // Control FSM with registered outputs
    // -------------------------------------------------------------------------
    state_t     state;
    logic [3:0] hold_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cursor   <= CENTER;
            C        <= 9'b000010000;
            writeEn  <= 1'b0;
            reject   <= 1'b0;
            hold_cnt <= '0;
        end else begin
            reject <= 1'b0;
            case (state)
                IDLE: begin
                    // Select takes precedence, so a move never lands in
                    // the same cycle as a write request.
                    if (press[B_SEL]) begin
                        if (game_over || occ[cursor]) begin
                            reject <= 1'b1;
                        end else begin
                            state    <= WRITE;
                            writeEn  <= 1'b1;
                            hold_cnt <= 4'(WE_HOLD - 1);
                        end
                    end else if (dir_press) begin
                        cursor <= mv_cursor;
                        C      <= 9'd1 << mv_cursor;
                    end
                end

                // cursor and C are untouched here, so C is stable for
                // the whole pulse. game_over cannot shorten the pulse.
                WRITE: begin
                    if (hold_cnt == 4'd0) begin
                        writeEn <= 1'b0;
                        state   <= RELEASE;
                    end else begin
                        hold_cnt <= hold_cnt - 4'd1;
                    end
                end

                // Wait until select is released so a held button cannot
                // start a second write.
                RELEASE: begin
                    writeEn <= 1'b0;
                    if (!level[B_SEL]) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state   <= IDLE;
                    writeEn <= 1'b0;
                end
            endcase
        end
    end

endmodule
